// File: rtl/parity_pkg.sv
// Shared definitions for the 7-bit parity receiver and generator.
package parity_pkg;

    // Data bits covered by parity; bit 4 is deliberately left out.
    localparam logic [6:0] PAR_MASK_DEF = 7'h6F;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage

// File: rtl/parity_rx_if.sv
// Serial line in, received word and status out.
interface parity_rx_if;
    logic       rx;
    logic [6:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    // Receiver side: consumes the line, produces the word.
    modport slave (
        input  rx,
        output data, valid, parity_err, frame_err, busy
    );

    // Line driver / word consumer side.
    modport master (
        output rx,
        input  data, valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/parity_calc.sv
// Even parity over the masked bits of a 7-bit word.
module parity_calc (
    input  logic [6:0] data,
    input  logic [6:0] mask,
    output logic       par
);
    assign par = ^(data & mask);
endmodule

// File: rtl/parity_rx.sv
// Serial receiver: start, 7 data bits LSB first, even parity, stop.
module parity_rx
    import parity_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 4,
    parameter logic [6:0] PAR_MASK     = PAR_MASK_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    parity_rx_if.slave   bus
);
    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state, state_nx;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [6:0]    shreg;
    logic          par_bit;
    logic          calc_par;
    logic          cnt_clr, shift_en, par_en, stop_en, busy;
    logic [6:0]    data_q;
    logic          valid_q, perr_q, ferr_q;

    parity_calc u_calc (
        .data (shreg),
        .mask (PAR_MASK),
        .par  (calc_par)
    );

    // Two-flop synchronizer; idles high so reset looks like a quiet line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!rx_s) state_nx = START;
            START:     if (cnt == HALF) state_nx = rx_s ? IDLE : DATA;
            DATA:      if (cnt == FULL && idx == 3'd6) state_nx = PARITY;
            PARITY:    if (cnt == FULL) state_nx = STOP;
            // A low stop bit means the line may still be held low; wait it out.
            STOP:      if (cnt == FULL) state_nx = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Per-state strobes: counter clear and sample enables.
    always_comb begin
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE, WAIT_IDLE: cnt_clr = 1'b1;
            START:   cnt_clr = (cnt == HALF);
            DATA:    begin shift_en = (cnt == FULL); cnt_clr = (cnt == FULL); end
            PARITY:  begin par_en   = (cnt == FULL); cnt_clr = (cnt == FULL); end
            STOP:    begin stop_en  = (cnt == FULL); cnt_clr = (cnt == FULL); end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Bit timing, shift register and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            cnt     <= cnt_clr ? '0 : cnt + CW'(1);
            valid_q <= stop_en;
            if (state == IDLE)
                idx <= '0;
            else if (shift_en)
                idx <= (idx == 3'd6) ? 3'd0 : idx + 3'd1;
            if (shift_en) shreg   <= {rx_s, shreg[6:1]};
            if (par_en)   par_bit <= rx_s;
            // Results only move on a completed frame and hold otherwise.
            if (stop_en) begin
                data_q <= shreg;
                perr_q <= par_bit ^ calc_par;
                ferr_q <= ~rx_s;
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = busy;

endmodule
